pipeline_trace_buffer: RTL
==========================

Name: pipeline_trace_buffer

Overview:
- Synthesizable successor to the CPU bench's per-cycle pipeline-register dump.
- Captures CHANNELS pipeline-stage words each valid cycle into a circular trace memory, tagged with a free-running cycle stamp.
- Stops capture a programmable number of samples after a trigger, then drains the trace oldest-first through a valid/ready read port.
- Sits beside the cpu core; channels are wired to the IF/ID, ID/EX, EX/MEM and MEM/WB buffer outputs.

Parameters:
- CHANNELS, 4, number of captured stage words per sample.
- DATA_WIDTH, 16, width of each channel word.
- DEPTH, 16, trace entries; power of two, at least 2.
- CYCLE_WIDTH, 16, width of the cycle stamp counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- arm  in  1  one-cycle request to clear and start capture.
- trigger  in  1  trigger event, sampled only in ARMED.
- post_count  in  log2(DEPTH)  samples still to capture after the trigger sample; sampled when the trigger is taken.
- capture_valid  in  1  the current cycle's channel data is a sample (stall cycles are held low).
- capture_data  in  CHANNELS*DATA_WIDTH  channel 0 in the LSBs.
- rd_valid  out  1  a trace entry is presented.
- rd_ready  in  1  consumer accepts the entry.
- rd_data  out  CHANNELS*DATA_WIDTH  channel words of the presented entry.
- rd_cycle  out  CYCLE_WIDTH  cycle stamp of the presented entry.
- rd_last  out  1  the presented entry is the final one.
- state  out  2  IDLE=0, ARMED=1, POST=2, READOUT=3.
- cycle_count  out  CYCLE_WIDTH  free-running cycle counter.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, cycle_count=0, wr_ptr=0, fill=0, post_remaining=0, rd_ptr=0. rd_valid=0, rd_last=0.
  - rd_data and rd_cycle are don't-care while rd_valid=0; the bench checks them only when rd_valid=1.
  - Reset mid-capture or mid-readout discards the whole trace.
- cycle_count increments every clock after reset and wraps modulo 2^CYCLE_WIDTH.
- Write rule in ARMED and POST: when capture_valid=1, write {cycle_count, capture_data} at wr_ptr.
  - wr_ptr increments modulo DEPTH.
  - fill increments and saturates at DEPTH; once full, the oldest entry is overwritten.
- IDLE: arm=1 -> ARMED next cycle, with wr_ptr=0 and fill=0. capture_valid and trigger are ignored.
- ARMED on trigger=1:
  - The same-cycle sample, if capture_valid=1, is written and is the trigger sample.
  - post_count=0 -> READOUT.
  - Otherwise -> POST, with post_remaining=post_count.
- ARMED on arm=1 (without trigger): restart, clearing wr_ptr and fill. arm has priority over trigger.
- POST:
  - Each written sample decrements post_remaining. The write that reaches 0 moves the block to READOUT.
  - trigger is ignored. arm=1 restarts into ARMED with the trace cleared.
- READOUT entry: rd_ptr = (wr_ptr - fill) mod DEPTH, and rd_left = fill.
- READOUT outputs:
  - rd_valid = (rd_left != 0).
  - rd_data and rd_cycle are read combinationally from the entry at rd_ptr.
  - rd_last = rd_valid and (rd_left == 1).
- READOUT transfer: rd_valid & rd_ready advances rd_ptr (mod DEPTH) and decrements rd_left.
  - The transfer with rd_last=1 returns the block to IDLE next cycle.
  - If fill=0 on entry, READOUT lasts one cycle with rd_valid=0, then returns to IDLE.
- Handshake: rd_data, rd_cycle and rd_last are stable while rd_valid=1 and rd_ready=0. arm is ignored in READOUT.
- No writes occur in IDLE or READOUT.

Decomposition:
- Package trace_pkg holds:
  - state encodings IDLE/ARMED/POST/READOUT;
  - the localparam entry width ENTRY_W = CYCLE_WIDTH + CHANNELS*DATA_WIDTH;
  - the pointer width function clog2.
- Sub-module trace_ram: DEPTH x ENTRY_W, synchronous write, asynchronous read, no reset on the array.
- The FSM, pointers and counters live in pipeline_trace_buffer.

Test Plan (CHANNELS=4, DATA_WIDTH=16, DEPTH=16):
- Reset then idle 5 cycles -> state=0, rd_valid=0, cycle_count=5. Assert reset low mid-count -> cycle_count=0 immediately.
- Basic trigger: arm; feed 6 samples with data=sample index; trigger with post_count=0 on the 6th -> READOUT.
  - Drain with rd_ready=1 gives 6 entries, data 0..5, increasing stamps.
  - rd_last is set only on data 5, then state=0.
- Wrap: arm; 20 samples; trigger on the 20th, post_count=3; 3 more samples.
  - Readout yields exactly 16 entries, data 7..22, oldest-first.
- Stalls and backpressure: samples with capture_valid toggling 1,0,1; rd_ready held low for 4 cycles mid-drain.
  - Only valid cycles are recorded.
  - rd_data and rd_cycle are held constant during backpressure.
  - No entry is lost or duplicated.
- Re-arm and ignore: arm during POST -> ARMED with fill=0. A trigger in IDLE or POST is ignored. arm in READOUT is ignored.
- Empty trace: arm, then trigger with capture_valid=0 and post_count=0 -> READOUT for one cycle with rd_valid=0, then IDLE.

Source files
------------

// File: rtl/pipeline_trace_buffer_pkg.sv
// Shared types and sizing for the pipeline trace buffer.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    POST    = 2'd2,
    READOUT = 2'd3
  } trace_state_e;

  localparam int CHANNELS_DEF    = 4;
  localparam int DATA_WIDTH_DEF  = 16;
  localparam int DEPTH_DEF       = 16;
  localparam int CYCLE_WIDTH_DEF = 16;
  localparam int ENTRY_W         = CYCLE_WIDTH_DEF + CHANNELS_DEF * DATA_WIDTH_DEF;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pipeline_trace_buffer_if.sv
// Valid/ready drain port of the trace buffer.
interface trace_rd_if #(
  parameter int DATA_W  = 64,
  parameter int CYCLE_W = 16
);
  logic               rd_valid;
  logic               rd_ready;
  logic [DATA_W-1:0]  rd_data;
  logic [CYCLE_W-1:0] rd_cycle;
  logic               rd_last;

  modport master (output rd_valid, rd_data, rd_cycle, rd_last, input rd_ready);
  modport slave  (input rd_valid, rd_data, rd_cycle, rd_last, output rd_ready);
endinterface

// File: rtl/pipeline_trace_buffer_ram.sv
// Trace storage: synchronous write, asynchronous read, array not reset.
module trace_ram
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = ENTRY_W,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/pipeline_trace_buffer.sv
// Circular pipeline trace capture with post-trigger stop and oldest-first drain.
module pipeline_trace_buffer
  import trace_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 16,
  parameter int CYCLE_WIDTH = 16,
  localparam int AW         = clog2(DEPTH),
  localparam int DW         = CHANNELS * DATA_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   arm,
  input  logic                   trigger,
  input  logic [AW-1:0]          post_count,
  input  logic                   capture_valid,
  input  logic [DW-1:0]          capture_data,
  trace_rd_if.master             rd,
  output logic [1:0]             state,
  output logic [CYCLE_WIDTH-1:0] cycle_count
);
  localparam int EW = CYCLE_WIDTH + DW;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  trace_state_e           state_q;
  logic [CYCLE_WIDTH-1:0] cycle_q;
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q, post_q;
  logic [AW:0]            fill_q, rd_left_q;

  logic          we, xfer;
  logic [AW-1:0] wr_ptr_d, rd_start;
  logic [AW:0]   fill_d;
  logic [EW-1:0] rdata;

  // arm wins over a same-cycle sample: the trace is being cleared anyway
  assign we       = ((state_q == ARMED) || (state_q == POST)) && capture_valid && !arm;
  assign wr_ptr_d = we ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign fill_d   = (we && (fill_q != FULL)) ? fill_q + 1'b1 : fill_q;
  // oldest entry, computed from post-write pointers so the final sample counts
  assign rd_start = wr_ptr_d - fill_d[AW-1:0];

  assign rd.rd_valid = (state_q == READOUT) && (rd_left_q != '0);
  assign rd.rd_last  = rd.rd_valid && (rd_left_q == (AW+1)'(1));
  assign xfer        = rd.rd_valid && rd.rd_ready;
  assign {rd.rd_cycle, rd.rd_data} = rdata;
  assign state       = state_q;
  assign cycle_count = cycle_q;

  trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk  (clock),
    .we   (we),
    .waddr(wr_ptr_q),
    .wdata({cycle_q, capture_data}),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cycle_q   <= '0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      post_q    <= '0;
      rd_ptr_q  <= '0;
      rd_left_q <= '0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
      case (state_q)
        IDLE: if (arm) begin
          state_q  <= ARMED;
          wr_ptr_q <= '0;
          fill_q   <= '0;
        end
        ARMED: if (arm) begin
          wr_ptr_q <= '0;
          fill_q   <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          fill_q   <= fill_d;
          if (trigger) begin
            if (post_count == '0) begin
              state_q   <= READOUT;
              rd_ptr_q  <= rd_start;
              rd_left_q <= fill_d;
            end else begin
              state_q <= POST;
              post_q  <= post_count;
            end
          end
        end
        POST: if (arm) begin
          state_q  <= ARMED;
          wr_ptr_q <= '0;
          fill_q   <= '0;
          post_q   <= '0;
        end else if (we) begin
          wr_ptr_q <= wr_ptr_d;
          fill_q   <= fill_d;
          post_q   <= post_q - 1'b1;
          if (post_q == AW'(1)) begin
            state_q   <= READOUT;
            rd_ptr_q  <= rd_start;
            rd_left_q <= fill_d;
          end
        end
        READOUT: begin
          if (rd_left_q == '0) begin
            state_q <= IDLE;
          end else if (xfer) begin
            rd_ptr_q  <= rd_ptr_q + 1'b1;
            rd_left_q <= rd_left_q - 1'b1;
            if (rd_left_q == (AW+1)'(1)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
